// File: rtl/phys_reg_file_mp.sv
// Multi-port physical register file with registered reads,
// write-first bypass and a per-preg ready scoreboard.
module phys_reg_file_mp #(
  parameter int NUM_PREGS = 64,
  parameter int XLEN      = 32,
  parameter int NUM_RD    = 4,
  parameter int NUM_WR    = 2,
  parameter int NUM_ALLOC = 2,
  localparam int PW       = $clog2(NUM_PREGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_RD*PW-1:0]      rd_idx,
  output logic [NUM_RD*XLEN-1:0]    rd_val,
  input  logic [NUM_WR-1:0]         wr_en,
  input  logic [NUM_WR*PW-1:0]      wr_idx,
  input  logic [NUM_WR*XLEN-1:0]    wr_val,
  input  logic [NUM_ALLOC-1:0]      alloc_en,
  input  logic [NUM_ALLOC*PW-1:0]   alloc_idx,
  output logic [NUM_PREGS-1:0]      rdy_vec
);

  localparam logic [PW:0] NP = NUM_PREGS[PW:0];

  logic [XLEN-1:0]        mem [NUM_PREGS];
  logic [NUM_PREGS-1:0]   rdy;
  logic [NUM_RD*XLEN-1:0] rd_nxt;

  function automatic logic ok_idx(logic [PW-1:0] i);
    return ({1'b0, i} < NP) && (i != '0);
  endfunction

  // Later write ports override earlier ones, matching write priority
  always_comb begin
    logic [PW-1:0] ri;
    ri = '0;
    rd_nxt = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      ri = rd_idx[r*PW +: PW];
      if (ok_idx(ri)) begin
        rd_nxt[r*XLEN +: XLEN] = mem[ri];
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && wr_idx[w*PW +: PW] == ri)
            rd_nxt[r*XLEN +: XLEN] = wr_val[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Alloc clears are applied after write sets so alloc wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++)
        mem[i] <= '0;
      rdy    <= '1;
      rd_val <= '0;
    end else begin
      rd_val <= rd_nxt;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && ok_idx(wr_idx[w*PW +: PW])) begin
          mem[wr_idx[w*PW +: PW]] <= wr_val[w*XLEN +: XLEN];
          rdy[wr_idx[w*PW +: PW]] <= 1'b1;
        end
      end
      for (int a = 0; a < NUM_ALLOC; a++) begin
        if (alloc_en[a] && ok_idx(alloc_idx[a*PW +: PW]))
          rdy[alloc_idx[a*PW +: PW]] <= 1'b0;
      end
    end
  end

  assign rdy_vec = rdy;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WR; i++) begin
        for (int j = i + 1; j < NUM_WR; j++) begin
          assert (!(wr_en[i] && wr_en[j] &&
                    wr_idx[i*PW +: PW] == wr_idx[j*PW +: PW] &&
                    wr_idx[i*PW +: PW] != '0))
          else $warning("write port collision on preg %0d",
                        wr_idx[i*PW +: PW]);
        end
      end
    end
  end

endmodule

// File: tb/tb_phys_reg_file_mp.sv
// Directed table-driven bench for phys_reg_file_mp:
// reads, bypass, scoreboard, preg 0 and reset behaviour.
module tb_phys_reg_file_mp;

  logic         clk = 0;
  logic         rst;
  logic [23:0]  rd_idx;
  logic [127:0] rd_val;
  logic [1:0]   wr_en;
  logic [11:0]  wr_idx;
  logic [63:0]  wr_val;
  logic [1:0]   alloc_en;
  logic [11:0]  alloc_idx;
  logic [63:0]  rdy_vec;

  int n_pass = 0;
  int n_tot  = 0;

  phys_reg_file_mp dut (
    .clk(clk), .rst(rst),
    .rd_idx(rd_idx), .rd_val(rd_val),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_val(wr_val),
    .alloc_en(alloc_en), .alloc_idx(alloc_idx),
    .rdy_vec(rdy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   we;
    logic [11:0]  wi;
    logic [63:0]  wv;
    logic [1:0]   ae;
    logic [11:0]  ai;
    logic [23:0]  ri;
    logic [127:0] er;
    logic [5:0]   rc;
    logic         rx;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    string n, logic [1:0] we,
    logic [5:0] wi0, logic [31:0] wv0,
    logic [5:0] wi1, logic [31:0] wv1,
    logic [1:0] ae, logic [5:0] ai0, logic [5:0] ai1,
    logic [23:0] ri, logic [127:0] er,
    logic [5:0] rc, logic rx);
    vec_t v;
    v.name = n;
    v.we = we;
    v.wi = {wi1, wi0};
    v.wv = {wv1, wv0};
    v.ae = ae;
    v.ai = {ai1, ai0};
    v.ri = ri;
    v.er = er;
    v.rc = rc;
    v.rx = rx;
    return v;
  endfunction

  task automatic check(string nm, logic [127:0] act,
                       logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic idle();
    wr_en = '0;
    wr_idx = '0;
    wr_val = '0;
    alloc_en = '0;
    alloc_idx = '0;
    rd_idx = '0;
  endtask

  initial begin
    rst = 1;
    idle();
    @(negedge clk);
    @(negedge clk);
    check("reset_rdy", 128'(rdy_vec), 128'({64{1'b1}}));
    check("reset_rd", rd_val, '0);

    // Read every preg on every port after reset
    rst = 0;
    for (int k = 0; k < 16; k++) begin
      for (int r = 0; r < 4; r++)
        rd_idx[r*6 +: 6] = 6'(4 * k + r);
      @(posedge clk);
      #1;
      check($sformatf("init_rd%0d", k), rd_val, '0);
      @(negedge clk);
    end
    check("init_rdy", 128'(rdy_vec), 128'({64{1'b1}}));

    vq.push_back(mk("wr5", 2'b01, 6'd5, 32'hDEADBEEF, 0, 0,
      0, 0, 0, 24'd0, 128'd0, 6'd5, 1));
    vq.push_back(mk("rd5", 0, 0, 0, 0, 0, 0, 0, 0,
      {6'd0, 6'd5, 6'd0, 6'd0},
      {32'd0, 32'hDEADBEEF, 32'd0, 32'd0}, 6'd5, 1));
    vq.push_back(mk("byp9", 2'b01, 6'd9, 32'h1234, 0, 0,
      0, 0, 0, {6'd0, 6'd0, 6'd5, 6'd9},
      {32'd0, 32'd0, 32'hDEADBEEF, 32'h1234}, 6'd9, 1));
    vq.push_back(mk("alloc7", 0, 0, 0, 0, 0,
      2'b01, 6'd7, 0, {6'd0, 6'd0, 6'd0, 6'd9},
      {32'd0, 32'd0, 32'd0, 32'h1234}, 6'd7, 0));
    vq.push_back(mk("wr7", 2'b10, 0, 0, 6'd7, 32'h77,
      0, 0, 0, {6'd7, 6'd0, 6'd0, 6'd0},
      {32'h77, 32'd0, 32'd0, 32'd0}, 6'd7, 1));
    vq.push_back(mk("aw7", 2'b01, 6'd7, 32'h700, 0, 0,
      2'b10, 0, 6'd7, {6'd0, 6'd0, 6'd0, 6'd7},
      {32'd0, 32'd0, 32'd0, 32'h700}, 6'd7, 0));
    vq.push_back(mk("rd7", 0, 0, 0, 0, 0, 0, 0, 0,
      {6'd0, 6'd0, 6'd7, 6'd0},
      {32'd0, 32'd0, 32'h700, 32'd0}, 6'd7, 0));
    vq.push_back(mk("wr0", 2'b01, 6'd0, 32'hFFFFFFFF, 0, 0,
      2'b01, 6'd0, 0, 24'd0, 128'd0, 6'd0, 1));
    vq.push_back(mk("rd0", 0, 0, 0, 0, 0, 0, 0, 0,
      24'd0, 128'd0, 6'd0, 1));
    vq.push_back(mk("dual3", 2'b11, 6'd3, 32'hA, 6'd3, 32'hB,
      0, 0, 0, {6'd0, 6'd0, 6'd0, 6'd3},
      {32'd0, 32'd0, 32'd0, 32'hB}, 6'd3, 1));
    vq.push_back(mk("rd3", 0, 0, 0, 0, 0, 0, 0, 0,
      {6'd0, 6'd3, 6'd0, 6'd0},
      {32'd0, 32'hB, 32'd0, 32'd0}, 6'd3, 1));
    vq.push_back(mk("two_wr", 2'b11, 6'd10, 32'h1010,
      6'd63, 32'h6363, 0, 0, 0,
      {6'd0, 6'd0, 6'd63, 6'd10},
      {32'd0, 32'd0, 32'h6363, 32'h1010}, 6'd63, 1));
    vq.push_back(mk("alloc2", 0, 0, 0, 0, 0,
      2'b11, 6'd10, 6'd63, {6'd5, 6'd9, 6'd63, 6'd10},
      {32'hDEADBEEF, 32'h1234, 32'h6363, 32'h1010},
      6'd10, 0));
    vq.push_back(mk("rdy63", 0, 0, 0, 0, 0, 0, 0, 0,
      {6'd63, 6'd0, 6'd0, 6'd0},
      {32'h6363, 32'd0, 32'd0, 32'd0}, 6'd63, 0));
    vq.push_back(mk("rdy9", 0, 0, 0, 0, 0, 0, 0, 0,
      {6'd0, 6'd0, 6'd0, 6'd3},
      {32'd0, 32'd0, 32'd0, 32'hB}, 6'd9, 1));

    foreach (vq[i]) begin
      wr_en = vq[i].we;
      wr_idx = vq[i].wi;
      wr_val = vq[i].wv;
      alloc_en = vq[i].ae;
      alloc_idx = vq[i].ai;
      rd_idx = vq[i].ri;
      @(posedge clk);
      #1;
      for (int r = 0; r < 4; r++)
        check($sformatf("%s_rd%0d", vq[i].name, r),
              128'(rd_val[r*32 +: 32]),
              128'(vq[i].er[r*32 +: 32]));
      check($sformatf("%s_rdy%0d", vq[i].name, vq[i].rc),
            128'(rdy_vec[vq[i].rc]), 128'(vq[i].rx));
      @(negedge clk);
    end

    // Reset in mid-stream; concurrent write/alloc must be dropped
    rst = 1;
    wr_en = 2'b01;
    wr_idx = {6'd0, 6'd5};
    wr_val = {32'd0, 32'h55};
    alloc_en = 2'b01;
    alloc_idx = {6'd0, 6'd9};
    rd_idx = {6'd3, 6'd7, 6'd9, 6'd5};
    @(posedge clk);
    #1;
    check("mid_rst_rd", rd_val, '0);
    check("mid_rst_rdy", 128'(rdy_vec), 128'({64{1'b1}}));
    @(negedge clk);
    rst = 0;
    wr_en = '0;
    alloc_en = '0;
    @(posedge clk);
    #1;
    check("post_rst_rd", rd_val, '0);
    check("post_rst_rdy", 128'(rdy_vec), 128'({64{1'b1}}));
    @(negedge clk);
    rd_idx = {6'd63, 6'd10, 6'd3, 6'd1};
    @(posedge clk);
    #1;
    check("post_rst_rd2", rd_val, '0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
